// File: rtl/data_mem_arbiter.sv
// Two-port arbiter that serialises access to a single-ported data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module data_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [15:0] mem_read_data,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_ack0, r_ack1, r_err0, r_err1;
  logic [15:0] r_rdata0, r_rdata1;

  logic        w_grant;
  logic        w_in_range;
  logic        w_access;
  logic [15:0] w_rd;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the port that was not served last wins; owner resets to 1 so port 0 wins first.
  assign w_grant = (req0 && req1) ? ~r_owner : req1;
`else
  assign w_grant = ~req0;
`endif

  assign w_in_range = (r_addr[15:3] == 13'd0);
  assign w_access   = (r_state == S_ACCESS);
  assign w_rd       = (!r_we && w_in_range) ? mem_read_data : 16'h0000;

  // Memory strobes are combinational from state so an async reset drops them before the next edge.
  assign mem_access_addr = w_access ? r_addr : 16'h0000;
  assign mem_write_data  = w_access ? r_wdata : 16'h0000;
  assign mem_write_en    = w_access && w_in_range && r_we;
  assign mem_read        = w_access && w_in_range && !r_we;

  assign busy   = (r_state != S_IDLE);
  assign owner  = r_owner;
  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign err0   = r_err0;
  assign err1   = r_err1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 16'h0000;
      r_rdata1 <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_owner <= w_grant;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= S_DONE;
          if (!r_owner) begin
            r_ack0   <= 1'b1;
            r_err0   <= ~w_in_range;
            r_rdata0 <= w_rd;
          end else begin
            r_ack1   <= 1'b1;
            r_err1   <= ~w_in_range;
            r_rdata1 <= w_rd;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request payload is latched only at acceptance; later changes on the ports are ignored.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && (req0 || req1)) begin
      r_we    <= w_grant ? we1 : we0;
      r_addr  <= w_grant ? addr1 : addr0;
      r_wdata <= w_grant ? wdata1 : wdata0;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a behavioural data memory, a reference memory image and
// per-scenario tasks with randomized transactions.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, busy, owner;

  logic [15:0] mem [0:7];
  logic [15:0] ref_mem [0:7];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .busy(busy), .owner(owner)
  );

  assign mem_read_data = mem[mem_access_addr[2:0]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_access_addr[2:0]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  // One complete transaction on one port, starting with the arbiter idle.
  task automatic run_txn(input bit port, input bit we, input logic [15:0] addr, input logic [15:0] wd);
    bit          inr;
    logic [15:0] exp_rd;
    int          wr0, rd0, cyc;
    bit          got;
    logic        a, e, oa, oe;
    logic [15:0] rd;
    inr    = (addr[15:3] == 13'd0);
    exp_rd = (inr && !we) ? ref_mem[addr[2:0]] : 16'h0000;
    wr0 = wr_cnt; rd0 = rd_cnt;
    @(negedge clk);
    if (!port) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else       begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1 || owner !== port) begin fails++; $display("FAIL accept: busy=%b owner=%b, expected busy=1 owner=%b", busy, owner, port); end
    tests++; if (mem_write_en !== (inr && we) || mem_read !== (inr && !we)) begin fails++; $display("FAIL strobes: we=%b rd=%b, expected we=%b rd=%b", mem_write_en, mem_read, inr && we, inr && !we); end
    tests++; if (mem_access_addr !== addr || mem_write_data !== wd) begin fails++; $display("FAIL mem_bus: addr=%h data=%h, expected addr=%h data=%h", mem_access_addr, mem_write_data, addr, wd); end
    got = 0; cyc = 0;
    while (!got && cyc < 8) begin
      @(posedge clk); #1; cyc++;
      if ((port ? ack1 : ack0) === 1'b1) got = 1;
    end
    tests++; if (!got || cyc != 1) begin fails++; $display("FAIL ack_latency: got=%0b cycles=%0d, expected ack after 1 cycle", got, cyc); end
    a  = port ? ack1 : ack0;  e  = port ? err1 : err0;  rd = port ? rdata1 : rdata0;
    oa = port ? ack0 : ack1;  oe = port ? err0 : err1;
    tests++; if (a !== 1'b1 || e !== !inr) begin fails++; $display("FAIL done_flags: ack=%b err=%b, expected ack=1 err=%b", a, e, !inr); end
    tests++; if (rd !== exp_rd) begin fails++; $display("FAIL rdata: got %h expected %h", rd, exp_rd); end
    tests++; if (oa !== 1'b0 || oe !== 1'b0) begin fails++; $display("FAIL other_port: ack=%b err=%b, expected 0 0", oa, oe); end
    tests++; if (mem_write_en !== 1'b0 || mem_read !== 1'b0 || mem_access_addr !== 16'h0 || mem_write_data !== 16'h0) begin fails++; $display("FAIL idle_bus: we=%b rd=%b addr=%h data=%h, expected all 0", mem_write_en, mem_read, mem_access_addr, mem_write_data); end
    if (!port) req0 = 0; else req1 = 0;
    if (inr && we) ref_mem[addr[2:0]] = wd;
    tests++; if (wr_cnt - wr0 != int'(inr && we) || rd_cnt - rd0 != int'(inr && !we)) begin fails++; $display("FAIL pulse_count: writes=%0d reads=%0d, expected %0d %0d", wr_cnt - wr0, rd_cnt - rd0, int'(inr && we), int'(inr && !we)); end
    @(posedge clk); #1;
    rd = port ? rdata1 : rdata0;
    tests++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL back_idle: ack0=%b ack1=%b busy=%b, expected 0 0 0", ack0, ack1, busy); end
    tests++; if (rd !== exp_rd) begin fails++; $display("FAIL rdata_hold: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1; req0 = 0; req1 = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk); #1;
    tests++; if (ack0 !== 0 || ack1 !== 0 || err0 !== 0 || err1 !== 0) begin fails++; $display("FAIL reset_flags: ack=%b%b err=%b%b, expected 0000", ack0, ack1, err0, err1); end
    tests++; if (busy !== 0 || mem_write_en !== 0 || mem_read !== 0 || owner !== 1) begin fails++; $display("FAIL reset_ctrl: busy=%b we=%b rd=%b owner=%b, expected 0 0 0 1", busy, mem_write_en, mem_read, owner); end
    tests++; if (rdata0 !== 0 || rdata1 !== 0 || mem_access_addr !== 0 || mem_write_data !== 0) begin fails++; $display("FAIL reset_data: r0=%h r1=%h addr=%h wd=%h, expected 0", rdata0, rdata1, mem_access_addr, mem_write_data); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 8; i++) run_txn(1'b1, 1'b1, 16'(i), 16'($urandom));
  endtask

  task automatic test_single_read();
    run_txn(1'b1, 1'b1, 16'h0003, 16'h1234);
    run_txn(1'b0, 1'b0, 16'h0003, 16'h0000);
    tests++; if (rdata0 !== 16'h1234) begin fails++; $display("FAIL single_read: rdata0=%h expected 1234", rdata0); end
  endtask

  task automatic test_write_read();
    run_txn(1'b1, 1'b1, 16'h0005, 16'hBEEF);
    run_txn(1'b1, 1'b0, 16'h0005, 16'h0000);
    tests++; if (rdata1 !== 16'hBEEF) begin fails++; $display("FAIL write_read: rdata1=%h expected beef", rdata1); end
  endtask

  task automatic test_out_of_range();
    run_txn(1'b0, 1'b1, 16'h0008, 16'hA5A5);
    tests++; if (mem[0] !== ref_mem[0]) begin fails++; $display("FAIL oor_mem: mem[0]=%h expected %h", mem[0], ref_mem[0]); end
    run_txn(1'b1, 1'b0, 16'hF001, 16'h0000);
  endtask

  task automatic test_tie();
    int   cnt0, cnt1;
    bit   grants[$];
    bit   exp_g[4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
    cnt0 = 0; cnt1 = 0;
    @(negedge clk); rst = 1; req0 = 0; req1 = 0;
    @(negedge clk); rst = 0;
    req0 = 1; we0 = 0; addr0 = 16'h0003; req1 = 1; we1 = 0; addr1 = 16'h0005;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) begin
        grants.push_back(1'b0); cnt0++; if (cnt0 == 2) req0 = 0;
        tests++; if (rdata0 !== ref_mem[3]) begin fails++; $display("FAIL tie_rdata0: got %h expected %h", rdata0, ref_mem[3]); end
      end
      if (ack1 === 1'b1) begin
        grants.push_back(1'b1); cnt1++; if (cnt1 == 2) req1 = 0;
        tests++; if (rdata1 !== ref_mem[5]) begin fails++; $display("FAIL tie_rdata1: got %h expected %h", rdata1, ref_mem[5]); end
      end
    end
    req0 = 0; req1 = 0;
    tests++; if (grants.size() != 4) begin fails++; $display("FAIL tie_count: got %0d grants expected 4", grants.size()); end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      tests++; if (grants[i] !== exp_g[i]) begin fails++; $display("FAIL tie_order[%0d]: got port %0d expected port %0d", i, grants[i], exp_g[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int          wr0;
    logic [15:0] old;
    run_txn(1'b0, 1'b1, 16'h0002, 16'h0A0A);
    old = ref_mem[2];
    wr0 = wr_cnt;
    @(negedge clk); req0 = 1; we0 = 1; addr0 = 16'h0002; wdata0 = 16'h5555;
    @(posedge clk); #1;
    tests++; if (mem_write_en !== 1'b1 || mem_write_data !== 16'h5555) begin fails++; $display("FAIL mid_access: we=%b data=%h, expected 1 5555", mem_write_en, mem_write_data); end
    #2 rst = 1;
    #1;
    tests++; if (mem_write_en !== 0 || mem_access_addr !== 0 || mem_write_data !== 0 || busy !== 0 || owner !== 1 || ack0 !== 0) begin fails++; $display("FAIL mid_reset: we=%b addr=%h data=%h busy=%b owner=%b ack0=%b, expected 0 0 0 0 1 0", mem_write_en, mem_access_addr, mem_write_data, busy, owner, ack0); end
    req0 = 0;
    @(negedge clk); rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests++; if (ack0 !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_no_ack: ack0=%b busy=%b, expected 0 0", ack0, busy); end
    end
    tests++; if (wr_cnt != wr0 || mem[2] !== old) begin fails++; $display("FAIL mid_no_write: writes=%0d mem2=%h, expected %0d %h", wr_cnt, mem[2], wr0, old); end
    run_txn(1'b0, 1'b0, 16'h0002, 16'h0000);
  endtask

  task automatic test_random();
    bit          p, w;
    logic [15:0] a;
    for (int n = 0; n < 40; n++) begin
      p = 1'($urandom);
      w = 1'($urandom);
      if ($urandom_range(0, 5) == 0) a = {13'($urandom_range(1, 8191)), 3'($urandom)};
      else a = 16'($urandom_range(0, 7));
      run_txn(p, w, a, 16'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      tests++; if (mem[i] !== ref_mem[i]) begin fails++; $display("FAIL mem_image[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_single_read();
    test_write_read();
    test_out_of_range();
    test_tie();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, port 0 (core load/store) / port 1 (debug/loader)
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  16  word address
- wdata0 / wdata1  in  16  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  out-of-range flag, valid with ack
- rdata0 / rdata1  out  16  read data, valid with ack
- mem_access_addr  out  16  to data memory
- mem_write_data  out  16  to data memory
- mem_write_en  out  1  to data memory
- mem_read  out  1  to data memory
- mem_read_data  in  16  from data memory (combinational read)
- busy  out  1  high in ACCESS or DONE
- owner  out  1  port currently or last served
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; ACCESS and DONE last exactly one cycle each.
REQ-004 In IDLE at a rising edge with any reqN high: SHALL select a winner, latch its we/addr/wdata, set owner, go to ACCESS.
REQ-005 Requester SHALL hold req, we, addr and wdata stable until it samples ack high; arbiter SHALL ignore changes after latching.
REQ-006 In ACCESS: mem_access_addr/mem_write_data SHALL drive latched values; mem_write_en = latched we, mem_read = !latched we.
REQ-007 Outside ACCESS: mem_write_en, mem_read, mem_access_addr and mem_write_data SHALL all be 0.
REQ-008 At the ACCESS->DONE edge: rdataN of owner SHALL capture mem_read_data for reads, 0 for writes; memory write commits on the same edge.
REQ-009 In DONE: ackN of owner SHALL be high for exactly that cycle; the other port's ack/err SHALL be 0.
REQ-010 DONE->IDLE unconditional; a req still high in DONE SHALL NOT be sampled, so a new request is accepted no earlier than the IDLE edge after DONE.
REQ-011 Latency: req sampled at edge E0 -> ack high in the cycle following E1; max throughput one access per 3 cycles.
REQ-012 Out-of-range: latched addr[15:3] != 0 SHALL keep mem_write_en and mem_read 0 in ACCESS, and give rdata 0 and errN = 1 with ack.
REQ-013 In-range accesses SHALL give errN = 0; rdataN SHALL hold its value until the next ack on that port.
REQ-014 Simultaneous req0 and req1 in IDLE SHALL be resolved per REQ-019; the loser stays pending and SHALL be served in the next IDLE cycle it is still high.

Reset
REQ-015 rst high SHALL force IDLE immediately; ack0/1, err0/1, busy, mem_write_en, mem_read = 0; rdata0/1, mem_access_addr, mem_write_data = 0; owner = 1.
REQ-016 rst asserted during ACCESS SHALL drop mem_write_en before the edge, so no write commits and no ack is issued.
REQ-017 After rst deasserts, first accepted request SHALL be sampled no earlier than the first rising edge with rst low.

Configuration
REQ-018 Macro ARB_ROUND_ROBIN_EN SHALL select the tie-break policy.
REQ-019 Defined: tie goes to the port not equal to owner (round robin; after reset port 0 wins first tie). Undefined: tie always goes to port 0 (fixed priority).

Verification
REQ-020 Single read: memory[3] = 0x1234, req0=1 we0=0 addr0=0x0003 -> mem_read high for one cycle, ack0 two edges later, rdata0 = 0x1234, err0 = 0.
REQ-021 Write then read: port 1 writes 0xBEEF to addr 5, then reads addr 5 -> mem_write_en one cycle with addr 5, second ack1 gives rdata1 = 0xBEEF.
REQ-022 Tie: req0 and req1 held high from reset -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it port 0 is served only while req0 is high, and port 1 is served once req0 drops.
REQ-023 Out-of-range: req0 write to addr 0x0008 -> no mem_write_en pulse, ack0 = 1, err0 = 1, rdata0 = 0, memory unchanged.
REQ-024 Reset mid-op: assert rst during ACCESS of a write of 0x5555 to addr 2 -> outputs zero immediately, memory[2] unchanged, no ack; next request completes normally.
